// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register.
// Carries the decode control word, register read data, register specifiers
// and extended immediate into the execute stage. It also detects load-use
// hazards, inserts one bubble for each one, and keeps a saturating count of
// every bubble it inserts.
module id_ex_pipe_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_n,

    // Decode stage
    input  logic                  i_ValidD,
    input  logic                  i_RegWriteD,
    input  logic                  i_MemtoRegD,
    input  logic                  i_MemWriteD,
    input  logic                  i_ALUSrcD,
    input  logic                  i_RegDstD,
    input  logic                  i_LoadD,
    input  logic [2:0]            i_ALUControlD,
    input  logic [DATA_WIDTH-1:0] i_RD1D,
    input  logic [DATA_WIDTH-1:0] i_RD2D,
    input  logic [DATA_WIDTH-1:0] i_SignImmD,
    input  logic [REG_ADDR_W-1:0] i_RsD,
    input  logic [REG_ADDR_W-1:0] i_RtD,
    input  logic [REG_ADDR_W-1:0] i_RdD,

    // Hazard / flow control
    input  logic                  i_StallE,
    input  logic                  i_FlushE,

    // Execute stage
    output logic                  o_RegWriteE,
    output logic                  o_MemtoRegE,
    output logic                  o_MemWriteE,
    output logic                  o_ALUSrcE,
    output logic                  o_RegDstE,
    output logic                  o_LoadE,
    output logic                  o_ValidE,
    output logic [2:0]            o_ALUControlE,
    output logic [DATA_WIDTH-1:0] o_RD1E,
    output logic [DATA_WIDTH-1:0] o_RD2E,
    output logic [DATA_WIDTH-1:0] o_SignImmE,
    output logic [REG_ADDR_W-1:0] o_RsE,
    output logic [REG_ADDR_W-1:0] o_RtE,
    output logic [REG_ADDR_W-1:0] o_RdE,

    output logic                  o_StallF,
    output logic                  o_StallD,
    output logic                  o_LwStall,
    output logic [CNT_W-1:0]      o_BubbleCount
);

    logic lwStall;
    logic insertBubble;
    logic cntAtMax;

    // Load-use detect. A load in E that targets a register the real
    // instruction in D reads must be separated from it by one bubble.
    // Register zero is never a true dependency.
    always_comb begin
        // NOTE: every always_comb output gets a value before any condition is
        // tested, so no path can leave it unassigned and infer a latch.
        lwStall      = 1'b0;
        insertBubble = 1'b0;
        if (o_ValidE && o_LoadE && i_ValidD && (o_RtE != '0) &&
            ((o_RtE == i_RsD) || (o_RtE == i_RtD))) begin
            lwStall = 1'b1;
        end
        // A held E stage beats a bubble: D is frozen too, so nothing is lost.
        insertBubble = !i_StallE && (lwStall || i_FlushE);
    end

    assign o_LwStall = lwStall;
    assign o_StallF  = lwStall | i_StallE;
    assign o_StallD  = lwStall | i_StallE;
    assign cntAtMax  = &o_BubbleCount;

    // E-stage register: hold on stall, zero on bubble, otherwise capture D.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before the edge, regardless of the
            // order of the statements.
            o_ValidE      <= 1'b0;
            o_RegWriteE   <= 1'b0;
            o_MemtoRegE   <= 1'b0;
            o_MemWriteE   <= 1'b0;
            o_ALUSrcE     <= 1'b0;
            o_RegDstE     <= 1'b0;
            o_LoadE       <= 1'b0;
            o_ALUControlE <= '0;
            o_RD1E        <= '0;
            o_RD2E        <= '0;
            o_SignImmE    <= '0;
            o_RsE         <= '0;
            o_RtE         <= '0;
            o_RdE         <= '0;
        end else if (i_StallE) begin
            // Hold: every E register keeps its value.
        end else if (insertBubble) begin
            o_ValidE      <= 1'b0;
            o_RegWriteE   <= 1'b0;
            o_MemtoRegE   <= 1'b0;
            o_MemWriteE   <= 1'b0;
            o_ALUSrcE     <= 1'b0;
            o_RegDstE     <= 1'b0;
            o_LoadE       <= 1'b0;
            o_ALUControlE <= '0;
            o_RD1E        <= '0;
            o_RD2E        <= '0;
            o_SignImmE    <= '0;
            o_RsE         <= '0;
            o_RtE         <= '0;
            o_RdE         <= '0;
        end else begin
            o_ValidE      <= i_ValidD;
            o_RegWriteE   <= i_RegWriteD;
            o_MemtoRegE   <= i_MemtoRegD;
            o_MemWriteE   <= i_MemWriteD;
            o_ALUSrcE     <= i_ALUSrcD;
            o_RegDstE     <= i_RegDstD;
            o_LoadE       <= i_LoadD;
            o_ALUControlE <= i_ALUControlD;
            o_RD1E        <= i_RD1D;
            o_RD2E        <= i_RD2D;
            o_SignImmE    <= i_SignImmD;
            o_RsE         <= i_RsD;
            o_RtE         <= i_RtD;
            o_RdE         <= i_RdD;
        end
    end

    // Bubble counter: counts each inserted bubble and sticks at all-ones.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_BubbleCount <= '0;
        end else if (insertBubble && !cntAtMax) begin
            o_BubbleCount <= o_BubbleCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios followed by
// random traffic, all compared against a stage-level reference model.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic        memtoReg;
        logic        memWrite;
        logic        aluSrc;
        logic        regDst;
        logic        load;
        logic [2:0]  aluCtl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } stage_t;

    logic   clk;
    logic   rstN;
    stage_t d;        // driven D-stage instruction
    logic   stallE;
    logic   flushE;

    stage_t obs;      // DUT E outputs (wide instance)
    stage_t obsS;     // DUT E outputs (narrow-counter instance)
    logic   stallF, stallD, lwStall;
    logic   stallFS, stallDS, lwStallS;
    logic [15:0] cnt;
    logic [1:0]  cntS;

    // Reference model state
    stage_t e;
    int     cntRef;
    int     cntRefS;

    int checks;
    int failures;

    id_ex_pipe_reg dut (
        .i_CLK(clk), .i_RST_n(rstN), .i_ValidD(d.valid),
        .i_RegWriteD(d.regWrite), .i_MemtoRegD(d.memtoReg), .i_MemWriteD(d.memWrite),
        .i_ALUSrcD(d.aluSrc), .i_RegDstD(d.regDst), .i_LoadD(d.load),
        .i_ALUControlD(d.aluCtl), .i_RD1D(d.rd1), .i_RD2D(d.rd2), .i_SignImmD(d.imm),
        .i_RsD(d.rs), .i_RtD(d.rt), .i_RdD(d.rd), .i_StallE(stallE), .i_FlushE(flushE),
        .o_RegWriteE(obs.regWrite), .o_MemtoRegE(obs.memtoReg), .o_MemWriteE(obs.memWrite),
        .o_ALUSrcE(obs.aluSrc), .o_RegDstE(obs.regDst), .o_LoadE(obs.load), .o_ValidE(obs.valid),
        .o_ALUControlE(obs.aluCtl), .o_RD1E(obs.rd1), .o_RD2E(obs.rd2), .o_SignImmE(obs.imm),
        .o_RsE(obs.rs), .o_RtE(obs.rt), .o_RdE(obs.rd),
        .o_StallF(stallF), .o_StallD(stallD), .o_LwStall(lwStall), .o_BubbleCount(cnt)
    );

    id_ex_pipe_reg #(.CNT_W(2)) dutS (
        .i_CLK(clk), .i_RST_n(rstN), .i_ValidD(d.valid),
        .i_RegWriteD(d.regWrite), .i_MemtoRegD(d.memtoReg), .i_MemWriteD(d.memWrite),
        .i_ALUSrcD(d.aluSrc), .i_RegDstD(d.regDst), .i_LoadD(d.load),
        .i_ALUControlD(d.aluCtl), .i_RD1D(d.rd1), .i_RD2D(d.rd2), .i_SignImmD(d.imm),
        .i_RsD(d.rs), .i_RtD(d.rt), .i_RdD(d.rd), .i_StallE(stallE), .i_FlushE(flushE),
        .o_RegWriteE(obsS.regWrite), .o_MemtoRegE(obsS.memtoReg), .o_MemWriteE(obsS.memWrite),
        .o_ALUSrcE(obsS.aluSrc), .o_RegDstE(obsS.regDst), .o_LoadE(obsS.load), .o_ValidE(obsS.valid),
        .o_ALUControlE(obsS.aluCtl), .o_RD1E(obsS.rd1), .o_RD2E(obsS.rd2), .o_SignImmE(obsS.imm),
        .o_RsE(obsS.rs), .o_RtE(obsS.rt), .o_RdE(obsS.rd),
        .o_StallF(stallFS), .o_StallD(stallDS), .o_LwStall(lwStallS), .o_BubbleCount(cntS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic stage_t randInstr(input int regRange);
        stage_t s;
        s.valid    = ($urandom_range(0, 7) != 0);
        s.regWrite = 1'($urandom);
        s.memtoReg = 1'($urandom);
        s.memWrite = 1'($urandom);
        s.aluSrc   = 1'($urandom);
        s.regDst   = 1'($urandom);
        s.load     = ($urandom_range(0, 2) == 0);
        s.aluCtl   = 3'($urandom);
        s.rd1      = $urandom;
        s.rd2      = $urandom;
        s.imm      = $urandom;
        s.rs       = 5'($urandom_range(0, regRange));
        s.rt       = 5'($urandom_range(0, regRange));
        s.rd       = 5'($urandom_range(0, regRange));
        return s;
    endfunction

    // Model: a load in E whose destination a real D instruction reads.
    function automatic logic refLwStall();
        return e.valid && e.load && d.valid && (e.rt != 0) &&
               ((e.rt == d.rs) || (e.rt == d.rt));
    endfunction

    // One clock cycle: inputs were set at the preceding falling edge.
    task automatic step();
        logic lw;
        #1;
        lw = refLwStall();
        check("lwStall", 128'(lwStall), 128'(lw));
        check("stallF", 128'(stallF), 128'(lw | stallE));
        check("stallD", 128'(stallD), 128'(lw | stallE));
        @(posedge clk);
        if (!stallE) begin
            if (lw || flushE) begin
                e       = '0;
                cntRef  = (cntRef  < 65535) ? cntRef  + 1 : 65535;
                cntRefS = (cntRefS < 3)     ? cntRefS + 1 : 3;
            end else begin
                e = d;
            end
        end
        #1;
        check("eStage", 128'(obs), 128'(e));
        check("eStageS", 128'(obsS), 128'(e));
        check("count", 128'(cnt), 128'(cntRef));
        check("countS", 128'(cntS), 128'(cntRefS));
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_e"}, 128'(obs), 128'(0));
        check({tag, "_eS"}, 128'(obsS), 128'(0));
        check({tag, "_cnt"}, 128'(cnt), 128'(0));
        check({tag, "_cntS"}, 128'(cntS), 128'(0));
    endtask

    task automatic doReset();
        rstN = 1'b0;
        e = '0; cntRef = 0; cntRefS = 0;
        #1;
        checkAllZero("asyncReset");
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0;
        e = '0; cntRef = 0; cntRefS = 0;
        rstN = 1'b0;
        d = randInstr(31); stallE = 1'b0; flushE = 1'b0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = randInstr(31);
            stallE = 1'($urandom); flushE = 1'($urandom);
            #1;
            checkAllZero("reset");
        end
        stallE = 1'b0; flushE = 1'b0;
        rstN = 1'b1;

        // First instruction after reset, one cycle latency.
        d = '0; d.valid = 1'b1; d.regWrite = 1'b1; d.aluCtl = 3'b010; d.rd1 = 32'h1234;
        step();
        check("firstValid", 128'(obs.valid), 128'(1));
        check("firstRd1", 128'(obs.rd1), 128'(32'h1234));

        // Load-use: lw with Rt=5 followed by an instruction reading r5.
        d = '0; d.valid = 1'b1; d.load = 1'b1; d.regWrite = 1'b1; d.memtoReg = 1'b1;
        d.rt = 5'd5; d.rs = 5'd2; d.imm = 32'd8;
        step();
        d = '0; d.valid = 1'b1; d.regWrite = 1'b1; d.rs = 5'd5; d.rt = 5'd9; d.rd = 5'd10;
        d.rd1 = 32'hdead_beef;
        #1;
        check("luLwStall", 128'(lwStall), 128'(1));
        check("luStallF", 128'(stallF), 128'(1));
        step();
        check("luBubbleValid", 128'(obs.valid), 128'(0));
        check("luBubbleCount", 128'(cnt), 128'(1));
        step();
        check("luDepEntered", 128'(obs.rs), 128'(5));
        check("luCountKept", 128'(cnt), 128'(1));

        // No dependency: Rt=0, and Rt=5 against Rs=6/Rt=7.
        d = '0; d.valid = 1'b1; d.load = 1'b1; d.rt = 5'd0;
        step();
        d = '0; d.valid = 1'b1; d.rs = 5'd0; d.rt = 5'd0;
        step();
        d = '0; d.valid = 1'b1; d.load = 1'b1; d.rt = 5'd5;
        step();
        d = '0; d.valid = 1'b1; d.rs = 5'd6; d.rt = 5'd7;
        #1;
        check("noDepLwStall", 128'(lwStall), 128'(0));
        step();
        // Invalid D instruction reading the load target: no stall.
        d = '0; d.valid = 1'b1; d.load = 1'b1; d.rt = 5'd4;
        step();
        d = '0; d.valid = 1'b0; d.rs = 5'd4;
        step();
        check("invalidNoBubble", 128'(cnt), 128'(1));

        // External stall for 3 cycles with D changing.
        d = randInstr(31);
        step();
        stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = randInstr(31);
            step();
        end
        stallE = 1'b0;
        d = randInstr(31);
        step();

        // Stall and flush together: hold wins; then the bubble.
        stallE = 1'b1; flushE = 1'b1;
        step();
        check("holdBeatsFlush", 128'(cnt), 128'(1));
        stallE = 1'b0;
        step();
        check("flushAfterHold", 128'(cnt), 128'(2));
        flushE = 1'b0;

        // Reset mid-stall discards the held instruction.
        d = randInstr(31); d.valid = 1'b1;
        step();
        stallE = 1'b1;
        step();
        #2;
        doReset();
        stallE = 1'b0;

        // Saturation on the 2-bit counter: 1,2,3,3,3.
        flushE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = randInstr(31);
            step();
            check("saturate", 128'(cntS), 128'((i < 3) ? i + 1 : 3));
        end
        flushE = 1'b0;

        // Random traffic with a narrow register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            d = randInstr(7);
            stallE = ($urandom_range(0, 5) == 0);
            flushE = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register. Captures the control word produced in decode (RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, RegDst, Load), plus register-file read data, register specifiers and the sign-extended immediate, and presents them to the execute stage.
- Owns load-use hazard detection. When a load in E writes a register that the instruction in D reads, it inserts one bubble into E and stalls F/D.
- Counts inserted bubbles for performance monitoring.

Parameters:
- DATA_WIDTH, 32, width of RD1/RD2/SignImm.
- REG_ADDR_W, 5, register specifier width.
- CNT_W, 16, bubble counter width.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RST_n  in  1  asynchronous active-low reset.
- i_ValidD  in  1  D-stage holds a real instruction.
- i_RegWriteD, i_MemtoRegD, i_MemWriteD, i_ALUSrcD, i_RegDstD, i_LoadD  in  1 each  decode control bits.
- i_ALUControlD  in  3  ALU operation.
- i_RD1D, i_RD2D  in  DATA_WIDTH  register read data.
- i_SignImmD  in  DATA_WIDTH  extended immediate.
- i_RsD, i_RtD, i_RdD  in  REG_ADDR_W  register specifiers.
- i_StallE  in  1  downstream hold of E (multi-cycle unit busy).
- i_FlushE  in  1  external bubble request.
- o_RegWriteE, o_MemtoRegE, o_MemWriteE, o_ALUSrcE, o_RegDstE, o_LoadE, o_ValidE  out  1 each.
- o_ALUControlE  out  3.
- o_RD1E, o_RD2E, o_SignImmE  out  DATA_WIDTH.
- o_RsE, o_RtE, o_RdE  out  REG_ADDR_W.
- o_StallF, o_StallD  out  1  hold PC and IF/ID register.
- o_LwStall  out  1  combinational load-use detect.
- o_BubbleCount  out  CNT_W  saturating bubble count.

Behaviour:
- Reset: the asynchronous assertion of i_RST_n=0 clears every registered output to 0, including o_ValidE and o_BubbleCount. Release is synchronous to the next edge. Reset mid-stall discards any held instruction.
- Load-use detect (combinational): lwstall = o_ValidE & o_LoadE & i_ValidD & (o_RtE != 0) & ((o_RtE == i_RsD) | (o_RtE == i_RtD)).
- o_LwStall = lwstall.
- o_StallF = o_StallD = lwstall | i_StallE.
- Per rising edge, the update priority is:
  1. i_StallE=1: all E registers hold, counter holds. A hold beats a bubble, because D is frozen too and no bubble is needed.
  2. Else if lwstall | i_FlushE: bubble. All control outputs, o_ValidE, data and specifier fields load 0. o_BubbleCount increments by 1, saturating at all-ones.
  3. Else: all fields load the D inputs, and o_ValidE = i_ValidD.
- Latency: a D input appears on the E outputs exactly 1 cycle later, absent stall or bubble.
- A load followed by a dependent instruction yields exactly one bubble. On the next cycle o_LoadE=0, lwstall deasserts, and the dependent instruction enters E.
- A bubble is architecturally inert: RegWrite=0 and MemWrite=0 guarantee no state change downstream.
- An invalid D instruction (i_ValidD=0) never triggers lwstall.
- The counter does not wrap. When it is at the maximum and a bubble occurs, it stays at the maximum.

Test Plan:
- Reset: hold i_RST_n=0 with random inputs -> all outputs 0. Release, drive RegWriteD=1, ALUControlD=3'b010, RD1D=32'h1234 -> E outputs match one cycle later, o_ValidE=1.
- Load-use: E holds lw with RtE=5, D has RsD=5 -> o_LwStall=1 and o_StallF=o_StallD=1. Next edge: E controls=0, o_ValidE=0, o_BubbleCount=1. Following cycle: stall=0, and the dependent instruction enters E the edge after.
- Register zero / no dependency: lw with RtE=0 and RsD=0, or RtE=5 with RsD=6, RtD=7 -> o_LwStall=0, no bubble, count unchanged.
- External stall: i_StallE=1 for 3 cycles while D inputs change -> E outputs frozen, o_StallD=1. Release -> the next D value loads.
- Simultaneous: i_StallE=1 and i_FlushE=1 -> hold wins, count unchanged. Drop i_StallE -> bubble inserted, count +1.
- Saturation: CNT_W=2, force 5 consecutive i_FlushE -> o_BubbleCount goes 1,2,3,3,3.
